uart_cmd_framer: RTL



---
 rtl/uart_frame_pkg.sv | 18 +
 rtl/uart_frame_timer.sv | 31 +++
 rtl/uart_cmd_framer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART command framer.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK
    } frame_state_t;

    localparam logic [1:0] ERR_LEN     = 2'b01;
    localparam logic [1:0] ERR_CHK     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hAA;

endpackage

// File: rtl/uart_frame_timer.sv
// Inter-byte watchdog: counts idle clocks while enabled, flags expiry on the
// (TIMEOUT_CYCLES-1)th count unless a clear arrives on that same cycle.
module uart_frame_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire_c
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    // A byte on the expiry cycle wins over the timeout.
    assign o_expire_c = i_enable && !i_clear && (r_count == LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clear || !i_enable || o_expire_c) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_cmd_framer.sv
// Assembles SYNC/CMD/LEN/PAYLOAD/CHK frames from the UART byte stream and
// publishes validated commands; aborts on bad length, checksum or timeout.
module uart_cmd_framer
    import uart_frame_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int unsigned MAX_LEN        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_done,
    output logic [7:0]                 frame_cmd,
    output logic [$clog2(MAX_LEN+1)-1:0] frame_len,
    output logic [8*MAX_LEN-1:0]       frame_payload,
    output logic                       frame_valid,
    output logic                       frame_err,
    output logic [1:0]                 err_code,
    output logic                       busy
);

    localparam int unsigned LEN_W     = $clog2(MAX_LEN + 1);
    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

    frame_state_t          r_state;
    logic [7:0]            r_cmd;
    logic [7:0]            r_acc;
    logic [LEN_W-1:0]      r_len;
    logic [LEN_W-1:0]      r_cnt;
    logic [8*MAX_LEN-1:0]  r_payload;
    logic                  w_timer_en;
    logic                  w_expire;

    assign w_timer_en = (r_state != ST_IDLE);

    uart_frame_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_clear    (rx_done),
        .i_enable   (w_timer_en),
        .o_expire_c (w_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cmd         <= '0;
            r_acc         <= '0;
            r_len         <= '0;
            r_cnt         <= '0;
            r_payload     <= '0;
            frame_cmd     <= '0;
            frame_len     <= '0;
            frame_payload <= '0;
            frame_valid   <= 1'b0;
            frame_err     <= 1'b0;
            err_code      <= '0;
            busy          <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            if (rx_done) begin
                case (r_state)
                    ST_IDLE: begin
                        if (rx_data == SYNC_BYTE) begin
                            r_state <= ST_CMD;
                            busy    <= 1'b1;
                        end
                    end
                    ST_CMD: begin
                        r_cmd   <= rx_data;
                        r_acc   <= rx_data;
                        r_state <= ST_LEN;
                    end
                    ST_LEN: begin
                        if (rx_data > MAX_LEN_B) begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_LEN;
                            r_state   <= ST_IDLE;
                            busy      <= 1'b0;
                        end else begin
                            r_len     <= LEN_W'(rx_data);
                            r_acc     <= r_acc ^ rx_data;
                            r_cnt     <= '0;
                            r_payload <= '0;
                            r_state   <= (rx_data == 8'd0) ? ST_CHK : ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: begin
                        for (int i = 0; i < int'(MAX_LEN); i++) begin
                            if (r_cnt == LEN_W'(i)) begin
                                r_payload[8*i +: 8] <= rx_data;
                            end
                        end
                        r_acc <= r_acc ^ rx_data;
                        r_cnt <= r_cnt + LEN_W'(1);
                        if (r_cnt == r_len - LEN_W'(1)) begin
                            r_state <= ST_CHK;
                        end
                    end
                    ST_CHK: begin
                        if (rx_data == r_acc) begin
                            frame_valid   <= 1'b1;
                            frame_cmd     <= r_cmd;
                            frame_len     <= r_len;
                            frame_payload <= r_payload;
                        end else begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_CHK;
                        end
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end else if (w_expire) begin
                frame_err <= 1'b1;
                err_code  <= ERR_TIMEOUT;
                r_state   <= ST_IDLE;
                busy      <= 1'b0;
            end
        end
    end

endmodule
